timer_arb: RTL and testbench
============================

TIMER_ARB -- requirements
Module: timer_arb

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, meaning the number of requesters sharing the timer.
REQ-002 The block SHALL have parameter DUR_W, default 8, meaning the width in bits of one duration value, counted in ticks.
REQ-003 The block SHALL have one clock and a synchronous active-high reset, port i_clk, input, 1 bit, with every register updating on its rising edge.
REQ-004 The block SHALL have port i_rst, input, 1 bit, a synchronous active-high reset.
REQ-005 The block SHALL have port i_tick, input, 1 bit, a one-cycle time-base pulse from the clock divider.
REQ-006 The block SHALL have port i_req, input, N_REQ bits, a level request per requester.
REQ-007 The block SHALL have port i_dur, input, N_REQ*DUR_W bits, the packed durations, with requester k at bits [k*DUR_W +: DUR_W].
REQ-008 The block SHALL have port o_gnt, output, N_REQ bits, a one-hot grant that is high while the timer is owned.
REQ-009 The block SHALL have port o_done, output, N_REQ bits, a one-cycle expiry pulse to the owner.
REQ-010 The block SHALL have port o_busy, output, 1 bit, which is high in RUN or DONE.
REQ-011 The block SHALL have port o_remain, output, DUR_W bits, the ticks still remaining for the current owner.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 In IDLE with any i_req bit high, the block SHALL pick the winner round-robin, searching from index ptr+1 modulo N_REQ upward.
REQ-014 At the same edge as the pick, the block SHALL update state to RUN, o_gnt to onehot(winner), cnt to i_dur[winner] and ptr to winner.
REQ-015 In IDLE with no request pending, all outputs SHALL remain zero.
REQ-016 A duration of 0 SHALL cause a transition from IDLE directly to DONE at the grant edge.
REQ-017 A duration of 0 SHALL pulse o_done[winner] at the grant edge, and o_gnt SHALL stay 0 throughout.
REQ-018 An i_tick pulse on the grant edge SHALL be ignored; counting SHALL start on the first tick after RUN is entered.
REQ-019 In RUN, each i_tick SHALL decrement cnt by 1, and o_remain SHALL equal cnt.
REQ-020 In RUN, when i_tick is high and cnt is 1, the block SHALL move to DONE.
REQ-021 On that expiry edge, the block SHALL set o_done[ptr] to 1, o_gnt to 0 and cnt to 0.
REQ-022 DONE SHALL last exactly one cycle, then clear o_done and return to IDLE.
REQ-023 The next grant SHALL occur no earlier than the edge after IDLE is re-entered.
REQ-024 If i_req[ptr] falls during RUN, the block SHALL abort at the next edge: state to IDLE, o_gnt and cnt to 0, and no o_done pulse.
REQ-025 If an abort and the final tick occur in the same cycle, the abort SHALL win and no done pulse SHALL be issued.
REQ-026 Requests and duration changes from non-owners during RUN SHALL be ignored.
REQ-027 Changes to i_dur[ptr] after the grant edge SHALL have no effect.
REQ-028 An owner that still holds i_req after DONE SHALL be treated as a new request, and it SHALL have the lowest priority in the next round-robin pick.
REQ-029 The output o_done SHALL never have more than one bit high.
REQ-030 The output o_gnt SHALL never have more than one bit high.

Reset
REQ-031 While i_rst is high at a rising edge, the block SHALL set state to IDLE and cnt to 0.
REQ-032 Reset SHALL set ptr to N_REQ-1, so that requester 0 has first priority after reset.
REQ-033 Reset SHALL force o_gnt, o_done, o_busy and o_remain to 0.
REQ-034 A reset during RUN or DONE SHALL discard the pending expiry, with no o_done pulse issued.
REQ-035 Reset SHALL take precedence over every other event in the same cycle.

Structure
REQ-036 The state encoding and the default constants N_REQ_DEF=4 and DUR_W_DEF=8 SHALL reside in the shared package vms_pkg.
REQ-037 The round-robin pick SHALL be implemented as a single combinational sub-module, rr_pick.
REQ-038 rr_pick SHALL take inputs req and ptr, and SHALL produce outputs valid and a one-hot winner.
REQ-039 The block SHALL contain no other sub-modules.
REQ-040 The tick SHALL come from the existing clock divider and SHALL NOT be generated inside the block.

Verification
REQ-041 Scenario 1: single request -- reset, then i_req=0001 with dur0=3 and a tick every 4 cycles -> o_gnt=0001, o_remain steps 3,2,1,0, o_done=0001 for 1 cycle at the third tick edge, o_busy drops the cycle after.
REQ-042 Scenario 2: contention -- i_req=1111 held continuously with all durations 1 -> grants issued in the order 0001, 0010, 0100, 1000, 0001, with one o_done per grant.
REQ-043 Scenario 3: zero duration -- i_req=0100 with dur2=0 -> o_done=0100 at the grant edge, o_gnt stays 0000, and the block is back in IDLE after 1 cycle.
REQ-044 Scenario 4: abort -- i_req[1] dropped with o_remain=2 -> o_gnt=0000 at the next edge and no o_done pulse; the abort also wins over a final tick arriving in the same cycle.
REQ-045 Scenario 5: reset mid-run -- i_rst pulsed for 1 cycle with o_remain=5 -> all outputs 0 and no done pulse; with i_req=1010 afterwards, grant 0010 comes first.
REQ-046 Scenario 6: tick on the grant edge -- i_tick coincides with the grant and dur=2 -> o_done occurs on the second subsequent tick, not the first.

Source files
------------

// File: rtl/vms_pkg.sv
// Shared definitions for the timer arbiter.
//   state_t    : FSM state encoding (IDLE, RUN, DONE)
//   N_REQ_DEF  : default number of requesters
//   DUR_W_DEF  : default duration width in ticks
//   idx_w()    : width of an index into n requesters (at least 1 bit)
package vms_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int DUR_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Searches req starting at index ptr+1 (mod N_REQ) upward and returns the
// first requester found as a one-hot vector.
//   req    : request vector, one bit per requester
//   ptr    : index of the previous winner (lowest priority this round)
//   valid  : at least one request is present
//   winner : one-hot winner, all zero when valid is low
module rr_pick
  import vms_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0]        req,
  input  logic [idx_w(N_REQ)-1:0] ptr,
  output logic                    valid,
  output logic [N_REQ-1:0]        winner
);

  localparam int PW = idx_w(N_REQ);

  // One extra bit so ptr + offset (up to 2*N_REQ-1) never wraps before
  // the explicit modulo step.
  logic [PW:0] sum;

  always_comb begin
    valid  = 1'b0;
    winner = '0;
    sum    = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      sum = {1'b0, ptr} + (PW+1)'(off);
      if (sum >= (PW+1)'(N_REQ)) begin
        sum = sum - (PW+1)'(N_REQ);
      end
      // First hit in search order wins; later candidates are masked.
      if (!valid && req[sum[PW-1:0]]) begin
        valid               = 1'b1;
        winner[sum[PW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_arb.sv
// Shared countdown timer with round-robin ownership.
// One requester at a time owns the timer; it is loaded with that
// requester's duration and counts down on i_tick. Expiry produces a
// one-cycle o_done pulse to the owner; dropping the request aborts.
//   i_clk    : clock
//   i_rst    : synchronous active-high reset
//   i_tick   : one-cycle time-base pulse from the external divider
//   i_req    : level request per requester
//   i_dur    : packed durations, requester k at [k*DUR_W +: DUR_W]
//   o_gnt    : one-hot grant, high while the timer is owned
//   o_done   : one-cycle expiry pulse to the owner
//   o_busy   : high in RUN or DONE
//   o_remain : ticks still remaining for the current owner
module timer_arb
  import vms_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int DUR_W = DUR_W_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_tick,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ*DUR_W-1:0] i_dur,
  output logic [N_REQ-1:0]       o_gnt,
  output logic [N_REQ-1:0]       o_done,
  output logic                   o_busy,
  output logic [DUR_W-1:0]       o_remain
);

  localparam int PW = idx_w(N_REQ);

  state_t           state_reg, state_next;
  logic [DUR_W-1:0] cnt_reg,   cnt_next;
  logic [PW-1:0]    ptr_reg,   ptr_next;
  logic [N_REQ-1:0] gnt_reg,   gnt_next;
  logic [N_REQ-1:0] done_reg,  done_next;

  logic             pick_valid;
  logic [N_REQ-1:0] pick_winner;
  logic [PW-1:0]    win_idx;
  logic [DUR_W-1:0] win_dur;
  logic [DUR_W-1:0] dur_arr [N_REQ];

  // Unpack the duration bus into one entry per requester.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_dur
    assign dur_arr[gi] = i_dur[gi*DUR_W +: DUR_W];
  end

  rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req    (i_req),
    .ptr    (ptr_reg),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      ptr_reg   <= PW'(N_REQ - 1);
      gnt_reg   <= '0;
      done_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ptr_reg   <= ptr_next;
      gnt_reg   <= gnt_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    ptr_next   = ptr_reg;
    gnt_next   = gnt_reg;
    done_next  = '0;

    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_winner[i]) begin
        win_idx = PW'(i);
      end
    end
    win_dur = dur_arr[win_idx];

    case (state_reg)
      IDLE: begin
        // i_tick is deliberately not looked at here, so a tick landing
        // on the grant edge never counts.
        if (pick_valid) begin
          ptr_next = win_idx;
          if (win_dur == '0) begin
            // Zero duration expires immediately and is never granted.
            state_next = DONE;
            done_next  = pick_winner;
            gnt_next   = '0;
            cnt_next   = '0;
          end else begin
            state_next = RUN;
            gnt_next   = pick_winner;
            cnt_next   = win_dur;
          end
        end
      end

      RUN: begin
        // Abort is checked first so it beats a coincident final tick.
        if (!i_req[ptr_reg]) begin
          state_next = IDLE;
          gnt_next   = '0;
          cnt_next   = '0;
        end else if (i_tick) begin
          if (cnt_reg == DUR_W'(1)) begin
            state_next = DONE;
            done_next  = gnt_reg;
            gnt_next   = '0;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg - DUR_W'(1);
          end
        end
      end

      DONE: begin
        state_next = IDLE;
        gnt_next   = '0;
        cnt_next   = '0;
      end

      default: begin
        state_next = IDLE;
        gnt_next   = '0;
        cnt_next   = '0;
      end
    endcase
  end

  assign o_gnt    = gnt_reg;
  assign o_done   = done_reg;
  assign o_busy   = (state_reg != IDLE);
  assign o_remain = cnt_reg;

endmodule

// File: tb/tb_timer_arb.sv
// Testbench for timer_arb: expected grants and done pulses are queued as
// stimulus is applied and consumed by a monitor as the DUT produces them;
// cycle-specific output values are checked directly.
module tb_timer_arb;
  import vms_pkg::*;

  localparam int N = 4;
  localparam int W = 8;

  logic           i_clk;
  logic           i_rst;
  logic           i_tick;
  logic [N-1:0]   i_req;
  logic [N*W-1:0] i_dur;
  logic [N-1:0]   o_gnt;
  logic [N-1:0]   o_done;
  logic           o_busy;
  logic [W-1:0]   o_remain;

  int total;
  int bad;

  logic [N-1:0] exp_gnt_q[$];
  logic [N-1:0] exp_done_q[$];

  timer_arb #(
    .N_REQ (N),
    .DUR_W (W)
  ) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_tick   (i_tick),
    .i_req    (i_req),
    .i_dur    (i_dur),
    .o_gnt    (o_gnt),
    .o_done   (o_done),
    .o_busy   (o_busy),
    .o_remain (o_remain)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic set_dur(input int k, input logic [W-1:0] v);
    i_dur[k*W +: W] = v;
  endtask

  task automatic chk_out(input string tag, input logic [N-1:0] gnt,
                         input logic [N-1:0] done, input logic busy,
                         input logic [W-1:0] remain);
    check_val({tag, "_gnt"},    32'(o_gnt),    32'(gnt));
    check_val({tag, "_done"},   32'(o_done),   32'(done));
    check_val({tag, "_busy"},   32'(o_busy),   32'(busy));
    check_val({tag, "_remain"}, 32'(o_remain), 32'(remain));
  endtask

  task automatic wait_drain(input int max_cycles);
    logic drained;
    drained = 1'b0;
    for (int c = 0; c < max_cycles; c++) begin
      step(1);
      if (exp_gnt_q.size() == 0 && exp_done_q.size() == 0) begin
        drained = 1'b1;
        break;
      end
    end
    check_val("drain", 32'(drained), 32'd1);
  endtask

  // Monitor: one-hot properties every cycle, grant order, done pulses.
  initial begin : monitor
    logic [N-1:0] prev_gnt;
    logic [N-1:0] e;
    prev_gnt = '0;
    forever begin
      @(negedge i_clk);
      check_val("gnt_onehot0",  32'($onehot0(o_gnt)),  32'd1);
      check_val("done_onehot0", 32'($onehot0(o_done)), 32'd1);
      if (o_gnt != '0 && o_gnt != prev_gnt) begin
        if (exp_gnt_q.size() > 0) begin
          e = exp_gnt_q.pop_front();
          check_val("gnt_order", 32'(o_gnt), 32'(e));
        end else begin
          check_val("gnt_unexpected", 32'(o_gnt), 32'd0);
        end
        $display("grant %b at %0t", o_gnt, $time);
      end
      if (o_done != '0) begin
        if (exp_done_q.size() > 0) begin
          e = exp_done_q.pop_front();
          check_val("done_order", 32'(o_done), 32'(e));
        end else begin
          check_val("done_unexpected", 32'(o_done), 32'd0);
        end
        $display("done  %b at %0t", o_done, $time);
      end
      prev_gnt = o_gnt;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    i_rst  = 1'b1;
    i_tick = 1'b0;
    i_req  = '0;
    i_dur  = '0;
    step(2);
    chk_out("reset", 4'b0000, 4'b0000, 1'b0, 8'd0);

    // Scenario 1: single request, dur 3, tick every 4 cycles.
    i_rst = 1'b0;
    set_dur(0, 8'd3);
    i_req = 4'b0001;
    exp_gnt_q.push_back(4'b0001);
    exp_done_q.push_back(4'b0001);
    step(1);
    chk_out("s1_grant", 4'b0001, 4'b0000, 1'b1, 8'd3);
    for (int k = 1; k <= 3; k++) begin
      step(3);
      i_tick = 1'b1;
      step(1);
      i_tick = 1'b0;
      check_val("s1_remain", 32'(o_remain), 32'(3 - k));
    end
    chk_out("s1_expire", 4'b0000, 4'b0001, 1'b1, 8'd0);
    i_req = '0;
    step(1);
    chk_out("s1_idle", 4'b0000, 4'b0000, 1'b0, 8'd0);

    // Scenario 2: full contention, all durations 1, tick held high.
    i_rst = 1'b1;
    step(1);
    i_rst = 1'b0;
    for (int k = 0; k < N; k++) set_dur(k, 8'd1);
    exp_gnt_q.push_back(4'b0001);  exp_done_q.push_back(4'b0001);
    exp_gnt_q.push_back(4'b0010);  exp_done_q.push_back(4'b0010);
    exp_gnt_q.push_back(4'b0100);  exp_done_q.push_back(4'b0100);
    exp_gnt_q.push_back(4'b1000);  exp_done_q.push_back(4'b1000);
    exp_gnt_q.push_back(4'b0001);  exp_done_q.push_back(4'b0001);
    i_tick = 1'b1;
    i_req  = 4'b1111;
    wait_drain(60);
    i_req  = '0;
    i_tick = 1'b0;
    step(2);
    chk_out("s2_idle", 4'b0000, 4'b0000, 1'b0, 8'd0);

    // Scenario 3: zero duration on requester 2.
    set_dur(2, 8'd0);
    i_req = 4'b0100;
    exp_done_q.push_back(4'b0100);
    step(1);
    chk_out("s3_grant_edge", 4'b0000, 4'b0100, 1'b1, 8'd0);
    i_req = '0;
    step(1);
    chk_out("s3_idle", 4'b0000, 4'b0000, 1'b0, 8'd0);

    // Scenario 4a: abort with two ticks remaining.
    set_dur(1, 8'd4);
    i_req = 4'b0010;
    exp_gnt_q.push_back(4'b0010);
    step(1);
    chk_out("s4_grant", 4'b0010, 4'b0000, 1'b1, 8'd4);
    for (int k = 0; k < 2; k++) begin
      i_tick = 1'b1;
      step(1);
      i_tick = 1'b0;
    end
    check_val("s4_remain2", 32'(o_remain), 32'd2);
    i_req = '0;
    step(1);
    chk_out("s4_abort", 4'b0000, 4'b0000, 1'b0, 8'd0);
    step(2);

    // Scenario 4b: abort coincides with the final tick.
    set_dur(1, 8'd1);
    i_req = 4'b0010;
    exp_gnt_q.push_back(4'b0010);
    step(1);
    chk_out("s4b_grant", 4'b0010, 4'b0000, 1'b1, 8'd1);
    i_req  = '0;
    i_tick = 1'b1;
    step(1);
    i_tick = 1'b0;
    chk_out("s4b_abort", 4'b0000, 4'b0000, 1'b0, 8'd0);
    step(2);

    // Scenario 5: reset mid-run, then requester 0 has top priority.
    set_dur(1, 8'd5);
    set_dur(3, 8'd5);
    i_req = 4'b1010;
    exp_gnt_q.push_back(4'b1000);  // ptr is 1, so search starts at 2
    step(1);
    chk_out("s5_grant", 4'b1000, 4'b0000, 1'b1, 8'd5);
    i_rst  = 1'b1;
    i_tick = 1'b1;
    step(1);
    chk_out("s5_reset", 4'b0000, 4'b0000, 1'b0, 8'd0);
    i_rst  = 1'b0;
    i_tick = 1'b0;
    exp_gnt_q.push_back(4'b0010);
    step(1);
    chk_out("s5_regrant", 4'b0010, 4'b0000, 1'b1, 8'd5);
    i_req = '0;
    step(1);
    chk_out("s5_drop", 4'b0000, 4'b0000, 1'b0, 8'd0);
    step(1);

    // Scenario 6: tick on the grant edge is ignored.
    set_dur(0, 8'd2);
    i_req  = 4'b0001;
    i_tick = 1'b1;
    exp_gnt_q.push_back(4'b0001);
    exp_done_q.push_back(4'b0001);
    step(1);
    chk_out("s6_grant", 4'b0001, 4'b0000, 1'b1, 8'd2);
    i_tick = 1'b0;
    step(2);
    check_val("s6_hold", 32'(o_remain), 32'd2);
    i_tick = 1'b1;
    step(1);
    i_tick = 1'b0;
    chk_out("s6_tick1", 4'b0001, 4'b0000, 1'b1, 8'd1);
    step(1);
    i_tick = 1'b1;
    step(1);
    i_tick = 1'b0;
    chk_out("s6_tick2", 4'b0000, 4'b0001, 1'b1, 8'd0);
    i_req = '0;
    step(2);
    chk_out("s6_idle", 4'b0000, 4'b0000, 1'b0, 8'd0);

    check_val("gnt_q_left",  32'(exp_gnt_q.size()),  32'd0);
    check_val("done_q_left", 32'(exp_done_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
